// File: rtl/serial_deser_4bit_if.sv
// rtl/serial_deser_4bit_if.sv - word output handshake between the deserializer and its consumer
interface serial_deser_4bit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             d_valid;
  logic             d_ready;
  logic             parity_err;

  modport master (output D, output d_valid, output parity_err, input d_ready);
  modport slave  (input D, input d_valid, input parity_err, output d_ready);
endinterface

// File: rtl/serial_deser_4bit.sv
// rtl/serial_deser_4bit.sv - MSB-first serial-to-parallel collector with a one-word holding register
// Optional frame parity bit enabled by defining DESER_PARITY_EN.
module serial_deser_4bit #(
  parameter int WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   E,
  input  logic                   bit_en,
  input  logic                   flush,
  serial_deser_4bit_if.master    dout,
  output logic                   overrun
);

`ifdef DESER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
  localparam int SR_W = WIDTH;
`else
  localparam int FLEN = WIDTH;
  localparam int SR_W = WIDTH - 1;
`endif
  localparam int CW = $clog2(FLEN);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_next;
  logic [SR_W-1:0]   shift_reg;
  logic [CW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  word;
  logic              word_perr;
  logic              complete, accept, load, drop;

  // The final sampled bit lands directly in the word, so the shift reg only keeps the earlier bits.
`ifdef DESER_PARITY_EN
  assign word      = shift_reg;
  assign word_perr = ^{shift_reg, E};
`else
  assign word      = {shift_reg, E};
  assign word_perr = 1'b0;
`endif

  assign complete = bit_en && !flush && (bit_cnt == CW'(FLEN - 1));
  assign accept   = dout.d_valid && dout.d_ready;
  assign load     = complete && (state == EMPTY || accept);
  assign drop     = complete && (state == FULL) && !accept;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (flush) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (bit_en) begin
      shift_reg <= SR_W'({shift_reg, E});
      bit_cnt   <= complete ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (complete)            state_next = FULL;
      FULL:  if (accept && !complete) state_next = EMPTY;
      default:                        state_next = EMPTY;
    endcase
  end

  always_comb begin
    dout.d_valid = (state == FULL);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      dout.D  <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) dout.D  <= word;
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)      dout.parity_err <= 1'b0;
    else if (load)   dout.parity_err <= word_perr;
    else if (accept) dout.parity_err <= 1'b0;
  end
`else
  assign dout.parity_err = word_perr;
`endif

endmodule

// File: tb/tb_serial_deser_4bit.sv
// tb/tb_serial_deser_4bit.sv - directed-vector bench for serial_deser_4bit (default build, WIDTH=4)
module tb_serial_deser_4bit;
  logic clock = 1'b0;
  logic clear, E, bit_en, flush, overrun;
  int   n_vec = 0;
  int   n_err = 0;

  serial_deser_4bit_if #(.WIDTH(4)) dif ();

  serial_deser_4bit #(.WIDTH(4)) dut (
    .clock   (clock),
    .clear   (clear),
    .E       (E),
    .bit_en  (bit_en),
    .flush   (flush),
    .dout    (dif),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send(input logic b);
    E = b; bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send(w[i]);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic v, input logic ov);
    check({tag, ".D"}, 32'(dif.D), 32'(d));
    check({tag, ".valid"}, 32'(dif.d_valid), 32'(v));
    check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    check({tag, ".perr"}, 32'(dif.parity_err), 32'd0);
  endtask

  initial begin
    clear = 1'b0; E = 1'b0; bit_en = 1'b0; flush = 1'b0; dif.d_ready = 1'b0;
    tick();
    expect_out("reset", 4'd0, 1'b0, 1'b0);
    tick();
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("idle", 4'd0, 1'b0, 1'b0);
    end

    send(1); send(1); send(0);
    check("single.early_valid", 32'(dif.d_valid), 32'd0);
    send(1);
    expect_out("single", 4'd13, 1'b1, 1'b0);
    tick(); tick();
    expect_out("single.hold", 4'd13, 1'b1, 1'b0);
    dif.d_ready = 1'b1; tick(); dif.d_ready = 1'b0;
    check("single.accept", 32'(dif.d_valid), 32'd0);

    for (int i = 3; i >= 0; i--) begin
      send(4'b1101 >> i);
      for (int j = 0; j < 3; j++) begin
        if (i != 0) check("gap.early_valid", 32'(dif.d_valid), 32'd0);
        tick();
      end
    end
    expect_out("gap", 4'd13, 1'b1, 1'b0);

    send_word(4'b0110);
    expect_out("overrun.drop", 4'd13, 1'b1, 1'b1);
    dif.d_ready = 1'b1; tick(); dif.d_ready = 1'b0;
    check("overrun.accept", 32'(dif.d_valid), 32'd0);
    send_word(4'b0011);
    expect_out("overrun.next", 4'd3, 1'b1, 1'b1);
    dif.d_ready = 1'b1; tick(); dif.d_ready = 1'b0;

    clear = 1'b0; tick(); clear = 1'b1;
    expect_out("reclear", 4'd0, 1'b0, 1'b0);

    // Second word completes on the same edge the first is accepted.
    send_word(4'b1101);
    send(0); send(1); send(1);
    dif.d_ready = 1'b1;
    send(0);
    expect_out("b2b.boundary", 4'd6, 1'b1, 1'b0);
    tick();
    check("b2b.drain", 32'(dif.d_valid), 32'd0);
    dif.d_ready = 1'b0;

    send(1); send(1);
    flush = 1'b1; send(1); flush = 1'b0;
    send(1); send(0); send(1);
    check("flush.early_valid", 32'(dif.d_valid), 32'd0);
    send(0);
    expect_out("flush.word", 4'd10, 1'b1, 1'b0);

    // Flush on a completing edge with an accept pending: accept honoured, frame discarded.
    send(1); send(1); send(1);
    dif.d_ready = 1'b1; flush = 1'b1; send(1); flush = 1'b0; dif.d_ready = 1'b0;
    expect_out("flush.complete", 4'd10, 1'b0, 1'b0);
    send(0);
    check("flush.restart", 32'(dif.d_valid), 32'd0);
    send(1); send(1); send(1);
    expect_out("flush.after", 4'd7, 1'b1, 1'b0);

    send(1); send(1);
    #2 clear = 1'b0;
    #2 check("clear.async_valid", 32'(dif.d_valid), 32'd0);
    clear = 1'b1;
    tick();
    send(1); send(0); send(1);
    expect_out("clear.partial", 4'd0, 1'b0, 1'b0);
    send(0);
    expect_out("clear.word", 4'd10, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
